// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and helpers for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

  localparam int NOP_WORD = 0;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
// Module      : imem_array
// Description : DEPTH x DATA_W storage, synchronous write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_array
  import fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC, fetch FSM, IF/ID buffer and out-of-range fault around imem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 6,
  parameter int                 PC_W     = 32,
  parameter int                 JUMP_W   = 16,
  parameter logic [PC_W-1:0]    RESET_PC = 32,
  parameter logic [DATA_W-1:0]  NOP      = DATA_W'(NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [PC_W-1:0]   load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              jump_valid,
  input  logic [JUMP_W-1:0] jump_target,
  output logic [DATA_W-1:0] instr,
  output logic [PC_W-1:0]   instr_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] buf_instr,
  output logic [PC_W-1:0]   buf_pc,
  output logic              buf_valid,
  output logic              oob_fault
);

  localparam int              DEPTH    = depth_of(ADDR_W);
  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(DEPTH);
  localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);

  fetch_state_e      state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_next;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic              in_range;

  assign wr_en    = load_en & ~rst & (load_addr < DEPTH_PC);
  assign pc_next  = jump_valid ? PC_W'(jump_target) : pc + PC_ONE;
  assign in_range = pc_next < DEPTH_PC;

  imem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_imem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (load_addr[ADDR_W-1:0]),
    .wr_data (load_data),
    .rd_addr (pc_next[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC - PC_ONE;
      instr       <= NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      buf_instr   <= NOP;
      buf_pc      <= '0;
      buf_valid   <= 1'b0;
      oob_fault   <= 1'b0;
    end else if (state == S_IDLE) begin
      if (!load_en) begin
        state <= S_FETCH;
      end
    end else if (!load_en) begin
      if (flush) begin
        instr       <= NOP;
        instr_valid <= 1'b0;
        buf_instr   <= NOP;
        buf_valid   <= 1'b0;
        // Park one below the target so the next advance fetches the target.
        if (jump_valid) begin
          pc <= pc_next - PC_ONE;
        end
      end else if (jump_valid || !stall) begin
        pc       <= pc_next;
        instr_pc <= pc_next;
        if (in_range) begin
          instr       <= rd_data;
          instr_valid <= 1'b1;
        end else begin
          instr       <= NOP;
          instr_valid <= 1'b0;
          oob_fault   <= 1'b1;
        end
        if (!stall) begin
          buf_instr <= instr;
          buf_pc    <= instr_pc;
          buf_valid <= instr_valid;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed plus randomized bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [15:0] load_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        jump_valid = 1'b0;
  logic [15:0] jump_target = '0;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [15:0] buf_instr;
  logic [31:0] buf_pc;
  logic        buf_valid;
  logic        oob_fault;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .stall       (stall),
    .flush       (flush),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .buf_instr   (buf_instr),
    .buf_pc      (buf_pc),
    .buf_valid   (buf_valid),
    .oob_fault   (oob_fault)
  );

  always #5 clk = ~clk;

  // Reference model: a fetch "pointer" plus a pending-redirect flag meaning
  // the next fetch uses the pointer itself rather than pointer+1.
  logic [15:0] m_mem [64];
  bit          m_started = 0;
  bit          m_idle;
  bit          m_redirect;
  logic [31:0] m_pc;
  logic [15:0] m_instr, m_binstr;
  logic [31:0] m_ipc, m_bpc;
  bit          m_iv, m_bv, m_fault;

  always @(posedge clk) begin
    logic [31:0] nxt;
    if (rst) begin
      m_started = 1; m_idle = 1; m_redirect = 1; m_pc = 32'd32;
      m_instr = 16'h0; m_ipc = 0; m_iv = 0;
      m_binstr = 16'h0; m_bpc = 0; m_bv = 0; m_fault = 0;
    end else begin
      if (load_en && load_addr < 32'd64) m_mem[load_addr[5:0]] = load_data;
      if (m_idle) begin
        if (!load_en) m_idle = 0;
      end else if (!load_en) begin
        if (flush) begin
          m_instr = 16'h0; m_iv = 0; m_binstr = 16'h0; m_bv = 0;
          if (jump_valid) begin m_pc = {16'h0, jump_target}; m_redirect = 1; end
        end else if (jump_valid || !stall) begin
          if (!stall) begin m_binstr = m_instr; m_bpc = m_ipc; m_bv = m_iv; end
          if (jump_valid) nxt = {16'h0, jump_target};
          else nxt = m_redirect ? m_pc : m_pc + 1;
          m_redirect = 0; m_pc = nxt; m_ipc = nxt;
          if (nxt < 64) begin m_instr = m_mem[nxt[5:0]]; m_iv = 1; end
          else begin m_instr = 16'h0; m_iv = 0; m_fault = 1; end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      chk("instr", {16'h0, instr}, {16'h0, m_instr});
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_iv});
      chk("buf_instr", {16'h0, buf_instr}, {16'h0, m_binstr});
      chk("buf_valid", {31'h0, buf_valid}, {31'h0, m_bv});
      chk("oob_fault", {31'h0, oob_fault}, {31'h0, m_fault});
      if (m_iv) chk("instr_pc", instr_pc, m_ipc);
      if (m_bv) chk("buf_pc", buf_pc, m_bpc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    load_en = 0; stall = 0; flush = 0; jump_valid = 0; rst = 0;
  endtask

  task automatic jump_to(input logic [15:0] t);
    jump_valid = 1; jump_target = t;
    tick();
    jump_valid = 0;
  endtask

  logic [15:0] orig6;

  initial begin
    tick(); tick();
    chk("rst_instr", {16'h0, instr}, 32'h0);
    chk("rst_valid", {29'h0, instr_valid, buf_valid, oob_fault}, 32'h0);
    chk("rst_pc", instr_pc | buf_pc, 32'h0);

    // Fill the whole memory while sitting in IDLE.
    rst = 0; load_en = 1;
    for (int i = 0; i < 64; i++) begin
      load_addr = i;
      if (i >= 32 && i <= 35) load_data = 16'hA001 + 16'(i - 32);
      else if (i == 40)       load_data = 16'hBEEF;
      else                    load_data = 16'($urandom);
      tick();
    end
    orig6 = m_mem[6];
    idle_in();
    tick();
    tick();
    chk("first_instr", {16'h0, instr}, 32'h0000_A001);
    chk("first_pc", instr_pc, 32'd32);
    chk("model_first", {16'h0, m_instr}, 32'h0000_A001);
    tick();
    chk("second_instr", {16'h0, instr}, 32'h0000_A002);
    chk("buf_lag", {16'h0, buf_instr}, 32'h0000_A001);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_pc", instr_pc, 32'd33);
      chk("stall_hold_buf", {16'h0, buf_instr}, 32'h0000_A001);
    end
    stall = 0;
    tick();
    chk("resume_pc", instr_pc, 32'd34);
    chk("resume_instr", {16'h0, instr}, 32'h0000_A003);

    stall = 1;
    jump_to(16'd40);
    stall = 0;
    chk("jump_stall_instr", {16'h0, instr}, 32'h0000_BEEF);
    chk("jump_stall_pc", instr_pc, 32'd40);
    tick();

    flush = 1;
    jump_to(16'd33);
    flush = 0;
    chk("flush_valid", {30'h0, instr_valid, buf_valid}, 32'h0);
    tick();
    chk("post_flush_instr", {16'h0, instr}, 32'h0000_A002);
    chk("post_flush_pc", instr_pc, 32'd33);
    tick();

    load_en = 1; load_addr = 36; load_data = 16'h5A5A;
    tick();
    chk("load_freeze_pc", instr_pc, 32'd34);
    load_addr = 70; load_data = 16'hDEAD;
    tick();
    load_en = 0;
    jump_to(16'd6);
    chk("dropped_load", {16'h0, instr}, {16'h0, orig6});
    jump_to(16'd36);
    chk("loaded_word", {16'h0, instr}, 32'h0000_5A5A);

    jump_to(16'd60);
    for (int i = 0; i < 4; i++) tick();
    chk("oob_instr", {15'h0, instr_valid, instr}, 32'h0);
    chk("oob_fault_set", {31'h0, oob_fault}, 32'h1);
    tick();
    chk("oob_sticky", {31'h0, oob_fault}, 32'h1);
    jump_to(16'd32);
    chk("recover_instr", {16'h0, instr}, 32'h0000_A001);
    chk("recover_fault", {31'h0, oob_fault}, 32'h1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_clears_fault", {31'h0, oob_fault}, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 99) < 2);
      load_en     = ($urandom_range(0, 99) < 10);
      load_addr   = $urandom_range(0, 127);
      load_data   = 16'($urandom);
      stall       = ($urandom_range(0, 99) < 20);
      flush       = ($urandom_range(0, 99) < 8);
      jump_valid  = ($urandom_range(0, 99) < 15);
      jump_target = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
      tick();
    end
    idle_in();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
